// File: rtl/rx_top.sv
// UART receiver: 2-flop line synchronizer, mid-bit sampling, even-parity and stop-bit checks.
// Latency: RX_VALID pulses OVERSAMPLE/2 cycles into the stop bit (cycle 168 after the synced start edge at defaults).
// Backpressure: none; the stream is free-running and each word is presented for exactly one cycle.
module rx_top #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  RX_CLK,
    input  logic                  RX_RST,
    input  logic                  RX_DATA,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  RX_VALID,
    output logic                  PARITY_ERR,
    output logic                  FRAME_ERR,
    output logic                  RX_BUSY
);

    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [TW-1:0] TICK_SAMPLE = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    sync1;
    logic                    sync2;
    logic                    line;
    logic [TW-1:0]           tick;
    logic [BW-1:0]           bitcnt;
    logic [DATA_WIDTH-1:0]   shift;
    logic                    par_bit;
    logic                    sample_pt;
    logic                    tick_last;
    logic                    last_bit;

    // Two-flop synchronizer; resets to the idle-high level so reset never looks like a start edge.
    always_ff @(posedge RX_CLK) begin
        if (RX_RST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= RX_DATA;
            sync2 <= sync1;
        end
    end

    assign line = sync2;

    // State register.
    always_ff @(posedge RX_CLK) begin
        if (RX_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: every bit period lasts OVERSAMPLE ticks, decisions happen at the mid-bit sample.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!line) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (sample_pt && line) begin
                    state_nxt = IDLE;
                end else if (tick_last) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (tick_last && last_bit) begin
                    state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (tick_last) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leaving at the stop sample gives IDLE half a bit of slack before a back-to-back start.
                if (sample_pt) begin
                    state_nxt = line ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (line) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded strobes and the busy flag.
    always_comb begin
        sample_pt = (tick == TICK_SAMPLE);
        tick_last = (tick == TICK_LAST);
        last_bit  = (bitcnt == BIT_LAST);
        RX_BUSY   = (state != IDLE);
    end

    // Tick counter: the IDLE cycle that sees the falling edge counts as tick 0 of the start bit,
    // so START is entered at tick 1 and the start sample lands exactly OVERSAMPLE/2-1 cycles after the edge.
    always_ff @(posedge RX_CLK) begin
        if (RX_RST) begin
            tick <= '0;
        end else if (state_nxt != state) begin
            tick <= (state == IDLE) ? TW'(1) : '0;
        end else if (state == IDLE || state == WAIT_HIGH || tick_last) begin
            tick <= '0;
        end else begin
            tick <= tick + TW'(1);
        end
    end

    // Data bit counter, advanced at the end of each data bit period.
    always_ff @(posedge RX_CLK) begin
        if (RX_RST) begin
            bitcnt <= '0;
        end else if (state == DATA) begin
            if (tick_last) begin
                bitcnt <= bitcnt + BW'(1);
            end
        end else begin
            bitcnt <= '0;
        end
    end

    // Shift register fills from the top so the first (LSB) bit ends up in bit 0 after DATA_WIDTH samples.
    always_ff @(posedge RX_CLK) begin
        if (RX_RST) begin
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (state == DATA && sample_pt) begin
                shift <= {line, shift[DATA_WIDTH-1:1]};
            end
            if (state == PARITY && sample_pt) begin
                par_bit <= line;
            end
        end
    end

    // Result registers: updated with status on every completed frame, errored or not.
    always_ff @(posedge RX_CLK) begin
        if (RX_RST) begin
            DATA_OUT   <= '0;
            RX_VALID   <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            if (state == STOP && sample_pt) begin
                RX_VALID   <= 1'b1;
                DATA_OUT   <= shift;
                PARITY_ERR <= par_bit ^ (^shift);
                FRAME_ERR  <= ~line;
            end
        end
    end

endmodule

// File: tb/tb_rx_top.sv
// Randomized bench for rx_top: bench-side serializer drives frames, a queue scoreboard checks every word.
// Expected RX_VALID cycle = drive cycle of start bit + 2 (synchronizer) + 168.
// No backpressure on the DUT; the monitor flags any valid pulse without a queued expectation.
module tb_rx_top;

    localparam int DW  = 8;
    localparam int OS  = 16;
    localparam int LAT = 2 + (OS / 2 - 1) + (DW + 2) * OS + 1;

    logic          clk;
    logic          rst;
    logic          rx_line;
    logic [DW-1:0] data_out;
    logic          rx_valid;
    logic          parity_err;
    logic          frame_err;
    logic          rx_busy;

    rx_top #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .RX_CLK     (clk),
        .RX_RST     (rst),
        .RX_DATA    (rx_line),
        .DATA_OUT   (data_out),
        .RX_VALID   (rx_valid),
        .PARITY_ERR (parity_err),
        .FRAME_ERR  (frame_err),
        .RX_BUSY    (rx_busy)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
        logic          fe;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    int            cyc = 0;
    int            chk_cnt = 0;
    int            pass_cnt = 0;
    logic [DW-1:0] last_d = '0;
    logic          last_pe = 1'b0;
    logic          last_fe = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_valid", {31'd0, rx_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, e.d});
                check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
                check("valid_cycle", cyc, e.cyc);
                last_d  = e.d;
                last_pe = e.pe;
                last_fe = e.fe;
            end
        end
    end

    task automatic hold(input logic b, input int n);
        rx_line = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serialize one frame; the expectation comes from the frame's own fields, not from DUT internals.
    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s,
                              input int extra_low, input int gap);
        exp_t e;
        e.d   = d;
        e.pe  = p ^ (^d);
        e.fe  = ~s;
        e.cyc = cyc + LAT;
        q.push_back(e);
        hold(1'b0, OS);
        for (int i = 0; i < DW; i++) hold(d[i], OS);
        hold(p, OS);
        hold(s, OS);
        if (!s) hold(1'b0, extra_low);
        hold(1'b1, gap);
    endtask

    task automatic check_outputs(input string tag, input logic [DW-1:0] d, input logic pe, input logic fe);
        @(negedge clk);
        check({tag, "_data"}, {24'd0, data_out}, {24'd0, d});
        check({tag, "_perr"}, {31'd0, parity_err}, {31'd0, pe});
        check({tag, "_ferr"}, {31'd0, frame_err}, {31'd0, fe});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          p;
        logic          s;
        logic          saw_busy;
        int            gap;

        rst     = 1'b1;
        rx_line = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_data", {24'd0, data_out}, 32'd0);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_perr", {31'd0, parity_err}, 32'd0);
        check("reset_ferr", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, rx_busy}, 32'd0);
        @(posedge clk);
        #1;
        hold(1'b1, 10);

        // Clean frame
        send_frame(8'hA5, 1'b0, 1'b1, 0, 10);

        // Parity error, then a good frame clears it
        send_frame(8'h01, 1'b0, 1'b1, 0, 10);
        send_frame(8'h3C, 1'b0, 1'b1, 0, 10);

        // Framing error with a held-low line: busy stays high, no extra valid
        send_frame(8'h5A, 1'b0, 1'b0, 40, 0);
        @(negedge clk);
        check("break_busy_high", {31'd0, rx_busy}, 32'd1);
        @(posedge clk);
        #1;
        hold(1'b1, 5);
        @(negedge clk);
        check("break_busy_low", {31'd0, rx_busy}, 32'd0);
        @(posedge clk);
        #1;
        check_outputs("break_hold", 8'h5A, 1'b0, 1'b1);

        // Short low glitch: false start
        hold(1'b0, 4);
        saw_busy = 1'b0;
        rx_line  = 1'b1;
        repeat (24) begin
            @(negedge clk);
            if (rx_busy === 1'b1) saw_busy = 1'b1;
        end
        check("glitch_busy_pulse", {31'd0, saw_busy}, 32'd1);
        check("glitch_busy_end", {31'd0, rx_busy}, 32'd0);
        @(posedge clk);
        #1;
        check_outputs("glitch_hold", 8'h5A, 1'b0, 1'b1);

        // Back-to-back frames without idle gap
        send_frame(8'h00, 1'b0, 1'b1, 0, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 0, 10);

        // Reset during data bit 4 of 0x77
        d = 8'h77;
        hold(1'b0, OS);
        for (int i = 0; i < 4; i++) hold(d[i], OS);
        hold(d[4], 8);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_data", {24'd0, data_out}, 32'd0);
        check("midrst_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_perr", {31'd0, parity_err}, 32'd0);
        check("midrst_ferr", {31'd0, frame_err}, 32'd0);
        check("midrst_busy", {31'd0, rx_busy}, 32'd0);
        last_d  = '0;
        last_pe = 1'b0;
        last_fe = 1'b0;
        @(posedge clk);
        #1;
        rx_line = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b1, 20);
        send_frame(8'hC3, ^8'hC3, 1'b1, 0, 10);

        // Random frames with occasional parity and stop errors
        for (int n = 0; n < 40; n++) begin
            d   = DW'($urandom);
            p   = ($urandom_range(0, 9) < 7) ? ^d : ~(^d);
            s   = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
            gap = s ? $urandom_range(0, 12) : $urandom_range(2, 12);
            send_frame(d, p, s, $urandom_range(0, 30), gap);
        end

        // Every byte value with correct framing and small gaps
        for (int w = 0; w < 256; w++) begin
            d = DW'(w);
            send_frame(d, ^d, 1'b1, 0, $urandom_range(0, 3));
        end

        hold(1'b1, 200);
        check("all_frames_reported", q.size(), 32'd0);
        check("final_data_hold", {24'd0, data_out}, {24'd0, last_d});

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
